// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opsel codes, multiply variants, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // ALU operation select, same encoding as the combinational ALU
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  // Multiply variants, selected by opsel[1:0] when a multiply is requested
  localparam logic [1:0] MUL_LO  = 2'b00;
  localparam logic [1:0] MUL_H   = 2'b01;
  localparam logic [1:0] MUL_HSU = 2'b10;
  localparam logic [1:0] MUL_HU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative radix-2 shift-add multiplier with sign handling for MUL/MULH/MULHSU/MULHU.
// Latency: exactly XLEN cycles after i_start; o_last marks the final iteration, o_result valid then.
// Backpressure: none; the parent FSM owns the handshake and only starts it from IDLE.
module seq_alu_mul
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_variant,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] mcand_q, mcand_d, prod_q, prod_d, sum, fin;
  logic [XLEN-1:0]   mplier_q, mplier_d, mag1, mag2;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, hi_q, hi_d, sgn1, sgn2;

  // Operand conditioning: take magnitudes of the operands treated as signed
  always_comb begin
    sgn1 = (i_variant inside {MUL_LO, MUL_H, MUL_HSU}) && i_op1[XLEN-1];
    sgn2 = (i_variant != MUL_HSU) && (i_variant != MUL_HU) && i_op2[XLEN-1];
    mag1 = sgn1 ? -i_op1 : i_op1;
    mag2 = sgn2 ? -i_op2 : i_op2;
  end

  // One shift-add step; sign fix-up is folded into the final step
  always_comb begin
    sum      = prod_q + (mplier_q[0] ? mcand_q : '0);
    fin      = neg_q ? -sum : sum;
    o_last   = (cnt_q == CW'(1));
    o_result = hi_q ? fin[2*XLEN-1:XLEN] : fin[XLEN-1:0];
  end

  // Next-state for the iteration registers
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    if (i_start) begin
      mcand_d  = {{XLEN{1'b0}}, mag1};
      mplier_d = mag2;
      prod_d   = '0;
      cnt_d    = CW'(XLEN);
      neg_d    = sgn1 ^ sgn2;
      hi_d     = (i_variant != MUL_LO);
    end else if (cnt_q != '0) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = o_last ? fin : sum;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Iteration registers; reset aborts any multiply in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/compare/logic, iterative shifts and multiply.
// Latency: 1 cycle for single-cycle ops and zero shifts; 1+floor(s/STEP)+(s mod STEP) for shifts; 1+XLEN for multiply.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready, no accept during BUSY/DONE.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mul,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_slt
);
  localparam int SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SW-1:0]   rem_q, rem_d;
  logic            eq_q, eq_d, slt_q, slt_d;
  logic            is_mul_q, is_mul_d, shl_q, shl_d, arith_q, arith_d;

  logic            accept, lt, is_shift, step_big, mul_last;
  logic [SW-1:0]   shamt, rem_next;
  logic [XLEN-1:0] alu_res, sh_next, mul_res;

  assign accept   = (state_q == ST_IDLE) && i_valid;
  assign shamt    = i_op2[SW-1:0];
  assign is_shift = !i_mul && ((i_opsel == OP_SLL) || (i_opsel == OP_SRL));
  assign lt       = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));

  seq_alu_mul #(.XLEN(XLEN)) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (accept && i_mul),
    .i_variant (i_opsel[1:0]),
    .i_op1     (i_op1),
    .i_op2     (i_op2),
    .o_last    (mul_last),
    .o_result  (mul_res)
  );

  // Single-cycle datapath; shifts seed the result register with op1
  always_comb begin
    alu_res = '0;
    case (i_opsel)
      OP_ADD:          alu_res = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      OP_SLL, OP_SRL:  alu_res = i_op1;
      OP_SLT, OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt};
      OP_XOR:          alu_res = i_op1 ^ i_op2;
      OP_OR:           alu_res = i_op1 | i_op2;
      OP_AND:          alu_res = i_op1 & i_op2;
      default:         alu_res = '0;
    endcase
  end

  // One shift step: a full SHIFT_STEP while enough remains, else a single bit
  always_comb begin
    step_big = (rem_q >= SW'(SHIFT_STEP));
    rem_next = rem_q - (step_big ? SW'(SHIFT_STEP) : SW'(1));
    sh_next  = '0;
    if (shl_q)
      sh_next = step_big ? (result_q << SHIFT_STEP) : (result_q << 1);
    else if (arith_q)
      sh_next = step_big ? ($signed(result_q) >>> SHIFT_STEP) : ($signed(result_q) >>> 1);
    else
      sh_next = step_big ? (result_q >> SHIFT_STEP) : (result_q >> 1);
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid)
          state_d = (i_mul || (is_shift && (shamt != '0))) ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (is_mul_q ? mul_last : (rem_next == '0))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        o_valid = 1'b1;
        if (i_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: capture at accept, iterate while busy, hold otherwise
  always_comb begin
    result_d = result_q;
    rem_d    = rem_q;
    eq_d     = eq_q;
    slt_d    = slt_q;
    is_mul_d = is_mul_q;
    shl_d    = shl_q;
    arith_d  = arith_q;
    if (accept) begin
      eq_d     = (i_op1 == i_op2);
      slt_d    = lt;
      is_mul_d = i_mul;
      shl_d    = (i_opsel == OP_SLL);
      arith_d  = i_arith;
      rem_d    = shamt;
      result_d = i_mul ? '0 : alu_res;
    end else if (state_q == ST_BUSY) begin
      if (is_mul_q) begin
        if (mul_last)
          result_d = mul_res;
      end else begin
        result_d = sh_next;
        rem_d    = rem_next;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
      rem_q    <= '0;
      eq_q     <= 1'b0;
      slt_q    <= 1'b0;
      is_mul_q <= 1'b0;
      shl_q    <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      rem_q    <= rem_d;
      eq_q     <= eq_d;
      slt_q    <= slt_d;
      is_mul_q <= is_mul_d;
      shl_q    <= shl_d;
      arith_q  <= arith_d;
    end
  end

  assign o_result = result_q;
  assign o_eq     = eq_q;
  assign o_slt    = slt_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32, SHIFT_STEP=4) against a behavioural model.
// Latency: checks accept-to-valid cycle counts per op class.
// Backpressure: exercises held results under i_ready=0 and ignored requests outside IDLE.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_mul, i_sub, i_unsigned, i_arith;
  logic        o_valid, i_ready, o_eq, o_slt;
  logic [2:0]  i_opsel;
  logic [31:0] i_op1, i_op2, o_result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mul(i_mul), .i_opsel(i_opsel), .i_sub(i_sub), .i_unsigned(i_unsigned),
    .i_arith(i_arith), .i_op1(i_op1), .i_op2(i_op2), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_eq(o_eq), .o_slt(o_slt)
  );

  // Reference result from plain arithmetic on 64-bit values
  function automatic logic [31:0] model_res(input logic mul, input logic [2:0] op,
      input logic sub, input logic uns, input logic ar, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    logic [4:0]  s;
    s = b[4:0];
    if (mul) begin
      x = {{32{a[31] & (op[1:0] != 2'b11)}}, a};
      y = {{32{b[31] & !op[1]}}, b};
      p = x * y;
      return (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end
    case (op)
      3'd0:       return sub ? a - b : a + b;
      3'd1:       return a << s;
      3'd2, 3'd3: return {31'd0, uns ? (a < b) : ($signed(a) < $signed(b))};
      3'd4:       return a ^ b;
      3'd5:       return ar ? 32'($signed(a) >>> s) : a >> s;
      3'd6:       return a | b;
      default:    return a & b;
    endcase
  endfunction

  function automatic int model_busy(input logic mul, input logic [2:0] op, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    if (mul) return 32;
    if (op == 3'd1 || op == 3'd5) return s / 4 + s % 4;
    return 0;
  endfunction

  // Drive one request, scramble inputs after accept, wait for the result; busy=-1 on timeout
  task automatic run_op(input logic mul, input logic [2:0] op, input logic sub, input logic uns,
      input logic ar, input logic [31:0] a, input logic [31:0] b,
      output logic [31:0] res, output logic eq, output logic slt, output int busy);
    int lat;
    @(negedge clk);
    i_mul = mul; i_opsel = op; i_sub = sub; i_unsigned = uns; i_arith = ar;
    i_op1 = a; i_op2 = b; i_valid = 1'b1; i_ready = 1'b1;
    lat = 0;
    while (!o_ready && lat < 100) begin @(negedge clk); lat++; end
    @(posedge clk); #1;
    i_valid = 1'b0; i_op1 = $urandom; i_op2 = $urandom; i_opsel = 3'($urandom);
    i_mul = 1'($urandom); i_sub = 1'($urandom); i_arith = 1'($urandom); i_unsigned = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!o_valid && lat < 100) begin @(negedge clk); lat++; end
    res = o_result; eq = o_eq; slt = o_slt;
    busy = o_valid ? lat - 1 : -1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_mul = 1'b0; i_opsel = 3'd0;
    i_sub = 1'b0; i_unsigned = 1'b0; i_arith = 1'b0; i_op1 = '0; i_op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); i_rst = 1'b0;
    @(negedge clk);
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", o_ready); end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_valid); end
    vectors++; if (o_result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h want 0", o_result); end
    vectors++; if ({o_eq, o_slt} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {o_eq, o_slt}); end
  endtask

  task automatic test_add_sub();
    logic [31:0] r; logic eq, slt; int busy;
    run_op(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, r, eq, slt, busy);
    vectors++; if (r !== 32'd12) begin miscompares++; $display("FAIL add_result got %h want %h", r, 32'd12); end
    vectors++; if (busy !== 0) begin miscompares++; $display("FAIL add_busy got %0d want 0", busy); end
    vectors++; if ({eq, slt} !== 2'b01) begin miscompares++; $display("FAIL add_flags got %b want 01", {eq, slt}); end
    run_op(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, r, eq, slt, busy);
    vectors++; if (r !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub_result got %h want fffffffe", r); end
  endtask

  task automatic test_shift();
    logic [31:0] r; logic eq, slt; int busy;
    run_op(1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd31, r, eq, slt, busy);
    vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sra_result got %h want ffffffff", r); end
    vectors++; if (busy !== 10) begin miscompares++; $display("FAIL sra_busy got %0d want 10", busy); end
    run_op(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd31, r, eq, slt, busy);
    vectors++; if (r !== 32'h0000_0001) begin miscompares++; $display("FAIL srl_result got %h want 00000001", r); end
    vectors++; if (busy !== 10) begin miscompares++; $display("FAIL srl_busy got %0d want 10", busy); end
  endtask

  task automatic test_zero_shift();
    logic [31:0] r, a; logic eq, slt; int busy;
    a = $urandom;
    run_op(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, a, 32'h20, r, eq, slt, busy);
    vectors++; if (r !== a) begin miscompares++; $display("FAIL zshift_result got %h want %h", r, a); end
    vectors++; if (busy !== 0) begin miscompares++; $display("FAIL zshift_busy got %0d want 0", busy); end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic eq, slt; int busy;
    logic [31:0] want [4];
    want[0] = 32'h0000_0001; want[1] = 32'h0000_0000; want[2] = 32'hFFFF_FFFF; want[3] = 32'hFFFF_FFFE;
    for (int v = 0; v < 4; v++) begin
      run_op(1'b1, 3'(v), 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, eq, slt, busy);
      vectors++; if (r !== want[v]) begin miscompares++; $display("FAIL mul%0d_result got %h want %h", v, r, want[v]); end
      vectors++; if (busy !== 32) begin miscompares++; $display("FAIL mul%0d_busy got %0d want 32", v, busy); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    i_mul = 1'b0; i_opsel = 3'd0; i_sub = 1'b0; i_unsigned = 1'b0; i_arith = 1'b0;
    i_op1 = 32'd9; i_op2 = 32'd9; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1;
    i_op1 = 32'd3; i_op2 = 32'd4;   // next request held on the bus
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid%0d got %b want 1", k, o_valid); end
      vectors++; if (o_result !== 32'd18) begin miscompares++; $display("FAIL bp_result%0d got %h want %h", k, o_result, 32'd18); end
      vectors++; if ({o_eq, o_slt} !== 2'b10) begin miscompares++; $display("FAIL bp_flags%0d got %b want 10", k, {o_eq, o_slt}); end
      vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d got %b want 0", k, o_ready); end
      if (k < 2) @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({o_valid, o_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release got v/r %b want 01", {o_valid, o_ready}); end
    @(negedge clk);
    i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b1 || o_result !== 32'd7 || {o_eq, o_slt} !== 2'b01) begin
      miscompares++; $display("FAIL bp_second got v=%b r=%h f=%b want v=1 r=00000007 f=01", o_valid, o_result, {o_eq, o_slt});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r; logic eq, slt; int busy, seen;
    @(negedge clk);
    i_mul = 1'b1; i_opsel = 3'd0; i_op1 = $urandom | 32'h1; i_op2 = $urandom | 32'h1;
    i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if ({o_valid, o_ready} !== 2'b00) begin miscompares++; $display("FAIL rmul_busy got v/r %b want 00", {o_valid, o_ready}); end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rmul_valid got %b want 0", o_valid); end
    vectors++; if (o_result !== 32'd0) begin miscompares++; $display("FAIL rmul_result got %h want 0", o_result); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rmul_ready got %b want 1", o_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (o_valid) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rmul_ghost got %0d valid cycles want 0", seen); end
    run_op(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, r, eq, slt, busy);
    vectors++; if (r !== 32'd2 || busy !== 0) begin miscompares++; $display("FAIL rmul_add got r=%h busy=%0d want r=00000002 busy=0", r, busy); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, want; logic mul, sub, uns, ar, eq, slt, weq, wslt; logic [2:0] op; int busy, wbusy;
    for (int n = 0; n < 80; n++) begin
      mul = ($urandom_range(0, 3) == 0); op = 3'($urandom); sub = 1'($urandom);
      uns = 1'($urandom); ar = 1'($urandom); a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) b = a;
      want  = model_res(mul, op, sub, uns, ar, a, b);
      wbusy = model_busy(mul, op, b);
      weq   = (a == b);
      wslt  = uns ? (a < b) : ($signed(a) < $signed(b));
      run_op(mul, op, sub, uns, ar, a, b, r, eq, slt, busy);
      vectors++; if (r !== want) begin miscompares++; $display("FAIL rand%0d_result m=%b op=%0d a=%h b=%h got %h want %h", n, mul, op, a, b, r, want); end
      vectors++; if (busy !== wbusy) begin miscompares++; $display("FAIL rand%0d_busy got %0d want %0d", n, busy, wbusy); end
      vectors++; if (eq !== weq) begin miscompares++; $display("FAIL rand%0d_eq got %b want %b", n, eq, weq); end
      vectors++; if (slt !== wslt) begin miscompares++; $display("FAIL rand%0d_slt got %b want %b", n, slt, wslt); end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift();
    test_zero_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
